// File: rtl/fpau_norm_pkg.sv
// rtl/fpau_norm_pkg.sv - shared FPAU normaliser types, widths and helpers
package fpau_norm_pkg;

    localparam int FPAU_MANT_W = 25;
    localparam int FPAU_EXP_W  = 8;

    typedef struct packed {
        logic [FPAU_MANT_W-1:0] mant;
        logic [FPAU_EXP_W-1:0]  exp;
    } norm_beat_t;

    // Bits needed to hold a count in 0..width inclusive.
    function automatic int clog2_plus1(input int width);
        int r;
        r = 0;
        while ((1 << r) < width + 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lzc_tree.sv
// rtl/lzc_tree.sv - combinational log-depth leading-zero counter
module lzc_tree
    import fpau_norm_pkg::*;
#(
    parameter int WIDTH = FPAU_MANT_W,
    localparam int LZC_W = clog2_plus1(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic [LZC_W-1:0] lzc,
    output logic             all_zero
);

    localparam int LG = $clog2(WIDTH);
    localparam int P  = 1 << LG;

    logic [P-1:0]  padded;
    logic [P-1:0]  v_lvl [LG+1];
    logic [LG-1:0] c_lvl [LG+1][P];

    // Node i at level l covers 2^l bits, node 0 on the MSB side. Trailing
    // pad ones make an all-zero input count exactly WIDTH zeros.
    always_comb begin
        padded = '1;
        padded[P-1 -: WIDTH] = data;
        for (int l = 0; l <= LG; l++) begin
            v_lvl[l] = '0;
            for (int i = 0; i < P; i++) begin
                c_lvl[l][i] = '0;
            end
        end
        for (int i = 0; i < P; i++) begin
            v_lvl[0][i] = padded[P-1-i];
        end
        for (int l = 0; l < LG; l++) begin
            for (int i = 0; i < P/2; i++) begin
                v_lvl[l+1][i] = v_lvl[l][2*i] | v_lvl[l][2*i+1];
                c_lvl[l+1][i] = v_lvl[l][2*i] ? c_lvl[l][2*i]
                                              : LG'((1 << l) + int'(c_lvl[l][2*i+1]));
            end
        end
        lzc      = v_lvl[LG][0] ? LZC_W'(c_lvl[LG][0]) : LZC_W'(WIDTH);
        all_zero = ~|data;
    end

endmodule

// File: rtl/lzc_norm_pipe.sv
// rtl/lzc_norm_pipe.sv - two-stage pipelined leading-zero normaliser
module lzc_norm_pipe
    import fpau_norm_pkg::*;
#(
    parameter int WIDTH = FPAU_MANT_W,
    parameter int EXP_W = FPAU_EXP_W,
    localparam int LZC_W = clog2_plus1(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic [LZC_W-1:0] out_lzc,
    output logic             out_zero,
    output logic             out_uf
);

    localparam int CMP_W = (EXP_W > LZC_W) ? EXP_W : LZC_W;

    logic             rdy_q;
    logic             s1_valid;
    logic             s1_zero;
    logic [LZC_W-1:0] s1_lzc;
    logic [WIDTH-1:0] s1_mant;
    logic [EXP_W-1:0] s1_exp;
    logic             s2_valid;

    logic             s1_adv;
    logic             s2_adv;
    logic             s1_load;
    logic             s2_load;
    logic [LZC_W-1:0] lzc_c;
    logic             zero_c;
    logic             exp_gt;
    logic [EXP_W-1:0] exp_sub;

    lzc_tree #(.WIDTH(WIDTH)) u_lzc (
        .data     (in_mant),
        .lzc      (lzc_c),
        .all_zero (zero_c)
    );

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    // rdy_q keeps the input closed until the first edge after reset release.
    assign in_ready  = rdy_q & s1_adv;
    assign s1_load   = in_valid & in_ready;
    assign s2_load   = s2_adv & s1_valid;
    assign out_valid = s2_valid;

    assign exp_gt  = CMP_W'(s1_exp) > CMP_W'(s1_lzc);
    assign exp_sub = s1_exp - EXP_W'(s1_lzc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_lzc   <= '0;
            s1_mant  <= '0;
            s1_exp   <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (s1_adv) begin
                s1_valid <= s1_load;
            end
            if (s1_load) begin
                s1_zero <= zero_c;
                s1_lzc  <= lzc_c;
                s1_mant <= in_mant;
                s1_exp  <= in_exp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_mant <= '0;
            out_exp  <= '0;
            out_lzc  <= '0;
            out_zero <= 1'b0;
            out_uf   <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_load) begin
                out_mant <= s1_mant << s1_lzc;
                out_lzc  <= s1_lzc;
                out_zero <= s1_zero;
                if (s1_zero) begin
                    out_exp <= '0;
                    out_uf  <= 1'b0;
                end else if (exp_gt) begin
                    out_exp <= exp_sub;
                    out_uf  <= 1'b0;
                end else begin
                    out_exp <= '0;
                    out_uf  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb/tb_lzc_norm_pipe.sv - self-checking bench for lzc_norm_pipe
module tb_lzc_norm_pipe;

    localparam int W  = 25;
    localparam int E  = 8;
    localparam int LZ = 5;

    typedef struct packed {
        logic [W-1:0]  mant;
        logic [E-1:0]  exp;
        logic [LZ-1:0] lzc;
        logic          zero;
        logic          uf;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_mant;
    logic [E-1:0]  in_exp;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_mant;
    logic [E-1:0]  out_exp;
    logic [LZ-1:0] out_lzc;
    logic          out_zero;
    logic          out_uf;

    logic        v8_in_valid, v8_in_ready, v8_out_valid, v8_out_zero, v8_out_uf;
    logic [7:0]  v8_in_mant, v8_out_mant, v8_in_exp, v8_out_exp;
    logic [3:0]  v8_out_lzc;
    logic        v64_in_valid, v64_in_ready, v64_out_valid, v64_out_zero, v64_out_uf;
    logic [63:0] v64_in_mant, v64_out_mant;
    logic [7:0]  v64_in_exp, v64_out_exp;
    logic [6:0]  v64_out_lzc;

    int    checks = 0;
    int    failures = 0;
    beat_t q[$];
    beat_t cur_exp;
    logic  fired;

    always #5 clk = ~clk;

    lzc_norm_pipe #(.WIDTH(W), .EXP_W(E)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp), .out_valid(out_valid),
        .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
        .out_lzc(out_lzc), .out_zero(out_zero), .out_uf(out_uf)
    );

    lzc_norm_pipe #(.WIDTH(8), .EXP_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
        .in_mant(v8_in_mant), .in_exp(v8_in_exp), .out_valid(v8_out_valid),
        .out_ready(1'b1), .out_mant(v8_out_mant), .out_exp(v8_out_exp),
        .out_lzc(v8_out_lzc), .out_zero(v8_out_zero), .out_uf(v8_out_uf)
    );

    lzc_norm_pipe #(.WIDTH(64), .EXP_W(8)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64_in_valid), .in_ready(v64_in_ready),
        .in_mant(v64_in_mant), .in_exp(v64_in_exp), .out_valid(v64_out_valid),
        .out_ready(1'b1), .out_mant(v64_out_mant), .out_exp(v64_out_exp),
        .out_lzc(v64_out_lzc), .out_zero(v64_out_zero), .out_uf(v64_out_uf)
    );

    function automatic int clz(input logic [63:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (v[i]) return w - 1 - i;
        end
        return w;
    endfunction

    function automatic beat_t model(input logic [W-1:0] m, input logic [E-1:0] e);
        beat_t b;
        int n;
        n = clz(64'(m), W);
        b.lzc  = LZ'(n);
        b.zero = (m == '0);
        b.mant = m << n;
        if (b.zero) begin
            b.exp = '0;
            b.uf  = 1'b0;
        end else if (int'(e) > n) begin
            b.exp = E'(int'(e) - n);
            b.uf  = 1'b0;
        end else begin
            b.exp = '0;
            b.uf  = 1'b1;
        end
        return b;
    endfunction

    // One clock: check ready and any presented beat, then record transfers.
    task automatic step();
        beat_t got;
        logic  fin;
        @(negedge clk);
        got = {out_mant, out_exp, out_lzc, out_zero, out_uf};
        checks++;
        assert (in_ready === ((q.size() < 2) || out_ready)) else begin
            failures++;
            $error("FAIL in_ready got=%b exp=%b held=%0d", in_ready, (q.size() < 2) || out_ready, q.size());
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $error("FAIL unexpected_beat got=%h exp=none", got);
            end else begin
                assert (got === q[0]) else begin
                    failures++;
                    $error("FAIL beat got=%h exp=%h", got, q[0]);
                end
                if (out_ready) void'(q.pop_front());
            end
        end
        fin = in_valid && in_ready;
        @(posedge clk);
        if (fin) q.push_back(cur_exp);
        fired = fin;
        #1;
    endtask

    task automatic send(input logic [W-1:0] m, input logic [E-1:0] e, input beat_t x);
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        cur_exp  = x;
        fired    = 1'b0;
        for (int t = 0; t < 20 && !fired; t++) step();
        checks++;
        assert (fired === 1'b1) else begin
            failures++;
            $error("FAIL send_timeout got=%b exp=1", fired);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int t = 0; t < 10 && q.size() > 0; t++) step();
        checks++;
        assert (q.size() === 0) else begin
            failures++;
            $error("FAIL drain got=%0d exp=0", q.size());
        end
    endtask

    initial begin
        logic [W-1:0] bp_m [4];
        logic [E-1:0] bp_e [4];
        int           idx;
        logic         saw_low;
        logic [W-1:0] rm;
        logic [E-1:0] re;

        rst_n = 1'b0; in_valid = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b1;
        v8_in_valid = 1'b0; v8_in_mant = '0; v8_in_exp = '0;
        v64_in_valid = 1'b0; v64_in_mant = '0; v64_in_exp = '0;
        cur_exp = '0; fired = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert (out_valid === 1'b0) else begin failures++; $error("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++;
        assert ({out_mant, out_exp, out_lzc, out_zero, out_uf} === '0) else begin
            failures++; $error("FAIL rst_outputs got=%h exp=0", {out_mant, out_exp, out_lzc, out_zero, out_uf});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        assert (in_ready === 1'b1) else begin failures++; $error("FAIL rst_in_ready got=%b exp=1", in_ready); end

        // First beat also pins the two-cycle latency.
        in_valid = 1'b1; in_mant = 25'h1000000; in_exp = 8'd127;
        cur_exp = '{25'h1000000, 8'd127, 5'd0, 1'b0, 1'b0};
        step();
        in_valid = 1'b0;
        checks++;
        assert (out_valid === 1'b0) else begin failures++; $error("FAIL latency_early got=%b exp=0", out_valid); end
        step();
        checks++;
        assert (out_valid === 1'b1) else begin failures++; $error("FAIL latency_due got=%b exp=1", out_valid); end
        drain();

        send(25'h0000001, 8'd127, '{25'h1000000, 8'd103, 5'd24, 1'b0, 1'b0});
        send(25'h0000000, 8'd50,  '{25'h0000000, 8'd0,   5'd25, 1'b1, 1'b0});
        send(25'h0010000, 8'd5,   '{25'h1000000, 8'd0,   5'd8,  1'b0, 1'b1});
        send(25'h0010000, 8'd9,   '{25'h1000000, 8'd1,   5'd8,  1'b0, 1'b0});
        send(25'h0010000, 8'd8,   '{25'h1000000, 8'd0,   5'd8,  1'b0, 1'b1});
        drain();

        // Back-pressure: lzc 0,3,7,24 back to back, out_ready low for cycles 2..4.
        bp_m = '{25'h1000000, 25'h0200000, 25'h0020000, 25'h0000001};
        bp_e = '{8'd127, 8'd100, 8'd60, 8'd30};
        idx = 0; saw_low = 1'b0;
        for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 2 && c < 5);
            if (idx < 4) begin
                in_valid = 1'b1; in_mant = bp_m[idx]; in_exp = bp_e[idx];
                cur_exp  = model(bp_m[idx], bp_e[idx]);
            end else begin
                in_valid = 1'b0;
            end
            if (in_ready === 1'b0) saw_low = 1'b1;
            step();
            if (fired) idx++;
        end
        checks++;
        assert (saw_low === 1'b1) else begin failures++; $error("FAIL bp_ready_drop got=%b exp=1", saw_low); end
        checks++;
        assert (idx === 4) else begin failures++; $error("FAIL bp_accepted got=%0d exp=4", idx); end
        drain();

        // Reset with both stages full.
        out_ready = 1'b0;
        send(25'h0400000, 8'd20, model(25'h0400000, 8'd20));
        send(25'h0000100, 8'd90, model(25'h0000100, 8'd90));
        checks++;
        assert (out_valid === 1'b1) else begin failures++; $error("FAIL pre_reset_full got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        assert (out_valid === 1'b0) else begin failures++; $error("FAIL async_reset got=%b exp=0", out_valid); end
        checks++;
        assert (out_mant === '0) else begin failures++; $error("FAIL async_reset_mant got=%h exp=0", out_mant); end
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        assert (in_ready === 1'b1) else begin failures++; $error("FAIL post_reset_ready got=%b exp=1", in_ready); end
        for (int t = 0; t < 4; t++) step();
        checks++;
        assert (out_valid === 1'b0) else begin failures++; $error("FAIL stale_beat got=%b exp=0", out_valid); end

        // Random traffic with random back-pressure.
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || fired) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rm = W'($urandom) >> $urandom_range(0, W);
                re = ($urandom_range(0, 1) == 0) ? E'($urandom_range(0, 30)) : E'($urandom);
                in_mant = rm; in_exp = re; cur_exp = model(rm, re);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        drain();

        // Width sweep on the 8- and 64-bit builds.
        for (int k = 0; k < 40; k++) begin
            v8_in_mant  = 8'($urandom) >> $urandom_range(0, 8);
            v64_in_mant = {$urandom, $urandom} >> $urandom_range(0, 64);
            v8_in_exp = 8'd200; v64_in_exp = 8'd200;
            v8_in_valid = 1'b1; v64_in_valid = 1'b1;
            @(posedge clk); #1;
            v8_in_valid = 1'b0; v64_in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checks++;
            assert ({v8_out_valid, v64_out_valid} === 2'b11) else begin
                failures++; $error("FAIL sweep_valid got=%b exp=11", {v8_out_valid, v64_out_valid});
            end
            checks++;
            assert (v8_out_lzc === 4'(clz(64'(v8_in_mant), 8))
                    && v8_out_mant === (v8_in_mant << clz(64'(v8_in_mant), 8))) else begin
                failures++; $error("FAIL sweep8 got=%0d/%h exp=%0d in=%h", v8_out_lzc, v8_out_mant, clz(64'(v8_in_mant), 8), v8_in_mant);
            end
            checks++;
            assert (v64_out_lzc === 7'(clz(v64_in_mant, 64))
                    && v64_out_mant === (v64_in_mant << clz(v64_in_mant, 64))) else begin
                failures++; $error("FAIL sweep64 got=%0d/%h exp=%0d in=%h", v64_out_lzc, v64_out_mant, clz(v64_in_mant, 64), v64_in_mant);
            end
            checks++;
            assert ({v8_out_zero, v64_out_zero} === {v8_in_mant == '0, v64_in_mant == '0}) else begin
                failures++; $error("FAIL sweep_zero got=%b exp=%b", {v8_out_zero, v64_out_zero}, {v8_in_mant == '0, v64_in_mant == '0});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
